// File: rtl/tip_arty_clock_seq_pkg.sv
// tip_arty_clock_seq_pkg: shared state encodings, status-counter width and
// small constant helpers for the Arty clock/reset sequencer.
package tip_arty_clock_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_REL_SYS   = 3'd4,
    S_RUN       = 3'd5
  } seq_state_e;

  localparam int STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // A zero-length phase is meaningless; clamp to one cycle.
  function automatic int unsigned at_least1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (v == STAT_MAX) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/tip_arty_sync_2ff.sv
// tip_arty_sync_2ff: 1-bit two-flop synchronizer, synchronous active-low
// reset to 0. Ports: clk, rstnn, d_i (async in), q_o (synced out).
module tip_arty_sync_2ff (
  input  logic clk,
  input  logic rstnn,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/tip_arty_clock_reset_sequencer.sv
// tip_arty_clock_reset_sequencer: PLL reset / lock qualification and staged
// release of the system and peripheral domain resets.
// Ports: clk, rstnn (sync active-low), pll_locked (async), sw_reset_req,
//   pll_reset, rstnn_system, rstnn_peri, seq_state[2:0],
//   lock_loss_count[7:0], timeout_count[7:0].
// Build option: TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN enables the WAIT_LOCK timeout.
module tip_arty_clock_reset_sequencer
  import tip_arty_clock_seq_pkg::*;
#(
  parameter int unsigned PLL_RESET_CYCLES    = 8,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned PERI_DELAY_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  output logic              pll_reset,
  output logic              rstnn_system,
  output logic              rstnn_peri,
  output logic [2:0]        seq_state,
  output logic [STAT_W-1:0] lock_loss_count,
  output logic [STAT_W-1:0] timeout_count
);

  localparam int unsigned PRC = at_least1(PLL_RESET_CYCLES);
  localparam int unsigned LSC = at_least1(LOCK_STABLE_CYCLES);
  localparam int unsigned RHC = at_least1(RESET_HOLD_CYCLES);
  localparam int unsigned PDC = at_least1(PERI_DELAY_CYCLES);
  localparam int unsigned TOC = at_least1(LOCK_TIMEOUT_CYCLES);

  localparam int unsigned MAXP =
    max2(max2(max2(PRC, LSC), max2(RHC, PDC)), TOC);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] PR_LAST = CW'(PRC - 1);
  localparam logic [CW-1:0] LS_LAST = CW'(LSC - 1);
  localparam logic [CW-1:0] RH_LAST = CW'(RHC - 1);
  localparam logic [CW-1:0] PD_LAST = CW'(PDC - 1);

  logic lock_s;

  tip_arty_sync_2ff u_lock_sync (
    .clk   (clk),
    .rstnn (rstnn),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pll_reset_q, pll_reset_d;
  logic sys_q, sys_d;
  logic peri_q, peri_d;
  logic [STAT_W-1:0] llc_q, llc_d;
  logic lock_loss_ev;

`ifdef TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TOC - 1);
  logic [STAT_W-1:0] toc_q, toc_d;
  logic timeout_ev;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_loss_ev = 1'b0;
`ifdef TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN
    timeout_ev   = 1'b0;
`endif
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PR_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else begin
`ifdef TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            state_d    = S_PLL_RST;
            cnt_d      = '0;
            timeout_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      S_STABLE: begin
        // Any glitch restarts qualification from scratch.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LS_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == RH_LAST) begin
          state_d = S_REL_SYS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REL_SYS: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == PD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        // Lock loss has priority over a soft reset.
        if (!lock_s) begin
          state_d      = S_PLL_RST;
          cnt_d        = '0;
          lock_loss_ev = 1'b1;
        end else if (sw_reset_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the same edge.
    pll_reset_d = (state_d == S_PLL_RST);
    sys_d       = (state_d == S_REL_SYS) || (state_d == S_RUN);
    peri_d      = (state_d == S_RUN);
    llc_d       = lock_loss_ev ? sat_inc(llc_q) : llc_q;
`ifdef TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN
    toc_d       = timeout_ev ? sat_inc(toc_q) : toc_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_q       <= 1'b0;
      peri_q      <= 1'b0;
      llc_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_q       <= sys_d;
      peri_q      <= peri_d;
      llc_q       <= llc_d;
    end
  end

`ifdef TIP_ARTY_CLOCK_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      toc_q <= '0;
    end else begin
      toc_q <= toc_d;
    end
  end

  assign timeout_count = toc_q;
`else
  assign timeout_count = '0;
`endif

  assign pll_reset       = pll_reset_q;
  assign rstnn_system    = sys_q;
  assign rstnn_peri      = peri_q;
  assign seq_state       = state_q;
  assign lock_loss_count = llc_q;

endmodule
